movimenti_multi: RTL
====================

# movimenti_multi

Parametrised successor of the single-rectangle VGA mover. Holds N independent framed rectangles (cornici) that move once per video frame. Each rectangle can bounce off the screen edges, wrap around, or be nudged by hand. The block composites all of them per pixel with fixed priority into registered 8-bit RGB. It sits between the VGA timing generator (x, y, disp_en, VGA_VS) and the DAC, and exports the selected object's position for the 7-segment BCD path.

## Interface
- H, 1280: active horizontal pixels
- V, 1024: active vertical lines
- N, 4: object count (1..8)
- ALTEZZA, 120: object height in lines
- LARGHEZZA, 160: object width in pixels
- SPESSORE, 10: frame thickness; must satisfy 2*SPESSORE < min(ALTEZZA, LARGHEZZA)
- STEP, 2: pixels moved per frame tick (1..15)
- VGA_CLK  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-low
- VGA_VS  in  1  vertical sync from the timing generator, VGA_CLK domain
- disp_en  in  1  active-video flag
- x, y  in  11 each  current pixel coordinate
- sel  in  3  object index for manual control and readback
- btn_x, btn_y  in  1 each  active-low nudge requests
- dir_x, dir_y  in  1 each  nudge direction; 1 = increasing
- auto_en  in  1  autonomous motion of all objects
- wrap_mode  in  1  edge policy: 0 = bounce/clamp, 1 = wrap
- r, g, b  out  8 each  pixel colour, registered
- pos_x, pos_y  out  11 each  top-left position of object sel; 0 if sel >= N
- hit_id  out  4  top-priority object under the pixel; 4'hF if none (aligned with rgb)

## Operation
- Frame tick: VGA_VS passes through a 2-flop register chain. Its rising edge gives a 1-cycle frame_tick. All position updates happen only on frame_tick.
- Object state per object: px, py (11 b, top-left) and vx_neg, vy_neg (direction bits).
- Reset values: px = i*(H/N), py = V/2 - ALTEZZA/2, direction bits 0. r, g, b = 0. hit_id = 4'hF. pos_x, pos_y track object 0 if sel = 0.
- Motion sources, on each tick:
  - Auto (auto_en = 1): every object moves STEP along each axis in its current direction.
  - Manual: the object sel additionally responds to btn_x/btn_y low by moving STEP in dir_x/dir_y.
  - Manual overrides auto for that axis of that object. Auto direction bits are unchanged by manual moves.
- Bounce mode (wrap_mode = 0):
  - Legal range is px in [0, H-LARGHEZZA] and py in [0, V-ALTEZZA].
  - A candidate past a limit is clamped to the limit. If the move was auto, the axis direction bit toggles.
- Wrap mode:
  - Increasing: next = (p+STEP >= LIM) ? p+STEP-LIM : p+STEP, where LIM = H for x and V for y.
  - Decreasing: next = (p < STEP) ? p+LIM-STEP : p-STEP.
  - The object may straddle the right/bottom edge; off-screen pixels are not drawn, with no wrap-around drawing.
- Arithmetic is done in 12 bits to catch overflow before truncation to 11.
- Hit test per object:
  - inside: x in [px, px+LARGHEZZA) and y in [py, py+ALTEZZA).
  - frame: inside and within SPESSORE of any edge.
  - interior: inside and not frame.
- Compositing: the lowest index wins.
  - Frame colour = PALETTE[i].
  - Interior colour = PALETTE[i] >> 1 per channel.
  - Background = 0x0000FF (blue).
  - disp_en low forces 0x000000.
- sel >= N: manual inputs are ignored and pos_x/pos_y = 0.

## Timing
- Pixel pipeline, 2 cycles from (x, y, disp_en) to (r, g, b, hit_id):
  - Stage 1 registers the per-object frame/interior flags and delayed disp_en.
  - Stage 2 registers the priority result.
- Frame tick fires 3 cycles after the VGA_VS rising edge is presented. Positions change on the cycle after frame_tick. At most one update per VS pulse.
- pos_x/pos_y are registered: 1 cycle after a sel change or position update.
- Synchronous reset takes effect on the next VGA_CLK edge, even mid-frame or mid-tick. It has priority over frame_tick, and the 2-stage pipeline flushes to 0/4'hF.
- Positions never change during a frame except on the tick cycle, so a frame is never torn mid-line apart from the VS-aligned update.

## Structure
- Package movimenti_pkg holds:
  - COORD_W = 11.
  - The PALETTE array of 8 24-bit colours: red, green, yellow, magenta, cyan, white, orange, grey.
  - BG_COLOUR.
  - NO_HIT = 4'hF.
- Sub-module sprite_obj, instantiated N times by generate, holds:
  - Position and direction registers and the next-position logic for both edge modes.
  - The combinational frame/interior test.
  - Its index and reset position are parameters.
- The top level holds the VS synchroniser, the sel demux, the priority encoder, the pixel pipeline and the pos mux.

## Test plan
- Reset, then one VS pulse with auto_en = 0 and no buttons -> object 0 at (0, 452), object 1 at (320, 452), positions unchanged; pixel (0, 452) -> rgb FF0000, hit_id 0, two cycles later.
- auto_en = 1, bounce, object 3 at px = 1118, STEP = 2 -> after one tick px = 1120 (clamped), direction toggles; next tick px = 1118.
- wrap_mode = 1, sel = 0, btn_x low, dir_x = 0, px = 1 -> next tick px = 1279; pixel (1279, 452) drawn; x = 0 on that line not drawn.
- Objects 0 and 1 overlapping at (20, 460) -> hit_id 0 and colour from object 0. With disp_en low -> rgb 000000 and hit_id 4'hF.
- Reset asserted on the same cycle as frame_tick -> reset positions win and r, g, b are 0 on the next edge. sel = 6 with N = 4 -> pos_x = pos_y = 0 and buttons have no effect.

Source files
------------

// File: rtl/movimenti_multi_pkg.sv
// -----------------------------------------------------------------------------
// movimenti_pkg
// Shared definitions for the multi-rectangle VGA mover:
//   - COORD_W / CALC_W : coordinate width and the one-bit-wider math width
//   - PALETTE          : per-object frame colour, index 0 has top priority
//   - BG_COLOUR        : colour shown where no object is hit
//   - NO_HIT           : hit_id value when no object covers the pixel
//   - axis_upd_t       : result of one axis position step (position + limit flag)
//   - axis_step()      : next position along one axis, bounce or wrap policy
//   - half_colour()    : interior shade, every channel halved
// -----------------------------------------------------------------------------
package movimenti_pkg;

    localparam int COORD_W = 11;
    localparam int CALC_W  = 12;

    localparam logic [23:0] PALETTE [0:7] = '{
        24'hFF0000,   // red
        24'h00FF00,   // green
        24'hFFFF00,   // yellow
        24'hFF00FF,   // magenta
        24'h00FFFF,   // cyan
        24'hFFFFFF,   // white
        24'hFFA500,   // orange
        24'h808080    // grey
    };

    localparam logic [23:0] BG_COLOUR = 24'h0000FF;
    localparam logic [3:0]  NO_HIT    = 4'hF;

    typedef struct packed {
        logic [COORD_W-1:0] pos;
        logic               flip;   // bounce mode reached a limit in the direction of motion
    } axis_upd_t;

    // Interior shade: each 8-bit channel shifted right by one.
    function automatic logic [23:0] half_colour(input logic [23:0] c);
        return {(c[23:16] >> 1'b1), (c[15:8] >> 1'b1), (c[7:0] >> 1'b1)};
    endfunction

    // One step along an axis. Math is one bit wider than a coordinate so
    // that p+step and p-step overflow/underflow are visible before truncation.
    function automatic axis_upd_t axis_step(
        input logic [COORD_W-1:0] p,
        input logic               inc,
        input logic               wrap,
        input logic [CALC_W-1:0]  lim,
        input logic [CALC_W-1:0]  max_p,
        input logic [CALC_W-1:0]  step
    );
        axis_upd_t          res;
        logic [CALC_W-1:0]  p_w;
        logic [CALC_W-1:0]  sum;
        logic [CALC_W-1:0]  diff;
        logic [CALC_W-1:0]  nxt;

        p_w      = {1'b0, p};
        sum      = p_w + step;
        diff     = p_w - step;
        nxt      = p_w;
        res.flip = 1'b0;

        if (wrap) begin
            if (inc) begin
                if (sum >= lim) begin
                    nxt = sum - lim;
                end else begin
                    nxt = sum;
                end
            end else begin
                if (p_w < step) begin
                    nxt = p_w + lim - step;
                end else begin
                    nxt = diff;
                end
            end
        end else begin
            if (inc) begin
                // Reaching the upper limit (not only passing it) reverses auto motion.
                if (sum >= max_p) begin
                    nxt      = max_p;
                    res.flip = 1'b1;
                end else begin
                    nxt = sum;
                end
            end else begin
                if (p_w <= step) begin
                    nxt      = {CALC_W{1'b0}};
                    res.flip = 1'b1;
                end else if (diff > max_p) begin
                    // Object left over past the limit from wrap mode: pull it back in.
                    nxt = max_p;
                end else begin
                    nxt = diff;
                end
            end
        end

        res.pos = COORD_W'(nxt);
        return res;
    endfunction

endpackage

// File: rtl/movimenti_multi_sprite_obj.sv
// -----------------------------------------------------------------------------
// sprite_obj
// One framed rectangle: position/direction state, per-frame motion and the
// combinational pixel hit test.
// Ports:
//   clk, reset       pixel clock, synchronous active-low reset
//   frame_tick       one-cycle pulse per video frame; the only update slot
//   auto_en          autonomous motion in the current direction
//   wrap_mode        0 = bounce/clamp, 1 = wrap around
//   man_x, man_y     manual move request for this object (already decoded)
//   dir_x, dir_y     manual direction, 1 = increasing
//   x, y             current pixel
//   px, py           top-left position
//   frame_hit        pixel lies on the frame border
//   inner_hit        pixel lies inside the border
// -----------------------------------------------------------------------------
module sprite_obj
    import movimenti_pkg::*;
#(
    parameter int H         = 1280,
    parameter int V         = 1024,
    parameter int N         = 4,
    parameter int ALTEZZA   = 120,
    parameter int LARGHEZZA = 160,
    parameter int SPESSORE  = 10,
    parameter int STEP      = 2,
    parameter int IDX       = 0,
    parameter int RST_X     = IDX * (H / N),
    parameter int RST_Y     = V / 2 - ALTEZZA / 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               auto_en,
    input  logic               wrap_mode,
    input  logic               man_x,
    input  logic               man_y,
    input  logic               dir_x,
    input  logic               dir_y,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [COORD_W-1:0] px,
    output logic [COORD_W-1:0] py,
    output logic               frame_hit,
    output logic               inner_hit
);

    localparam logic [CALC_W-1:0] LIM_X  = CALC_W'(H);
    localparam logic [CALC_W-1:0] LIM_Y  = CALC_W'(V);
    localparam logic [CALC_W-1:0] MAX_X  = CALC_W'(H - LARGHEZZA);
    localparam logic [CALC_W-1:0] MAX_Y  = CALC_W'(V - ALTEZZA);
    localparam logic [CALC_W-1:0] STEP_C = CALC_W'(STEP);

    logic [COORD_W-1:0] px_r;
    logic [COORD_W-1:0] py_r;
    logic               vx_neg_r;
    logic               vy_neg_r;

    logic               inc_x_s;
    logic               inc_y_s;
    axis_upd_t          upd_x_s;
    axis_upd_t          upd_y_s;

    // Manual direction overrides the auto direction bit for that axis.
    assign inc_x_s = man_x ? dir_x : ~vx_neg_r;
    assign inc_y_s = man_y ? dir_y : ~vy_neg_r;
    assign upd_x_s = axis_step(px_r, inc_x_s, wrap_mode, LIM_X, MAX_X, STEP_C);
    assign upd_y_s = axis_step(py_r, inc_y_s, wrap_mode, LIM_Y, MAX_Y, STEP_C);

    // Position and direction state, updated only on the frame tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            px_r     <= COORD_W'(RST_X);
            py_r     <= COORD_W'(RST_Y);
            vx_neg_r <= 1'b0;
            vy_neg_r <= 1'b0;
        end else if (frame_tick) begin
            if (man_x || auto_en) begin
                px_r <= upd_x_s.pos;
            end
            if (!man_x && auto_en && upd_x_s.flip) begin
                vx_neg_r <= ~vx_neg_r;
            end
            if (man_y || auto_en) begin
                py_r <= upd_y_s.pos;
            end
            if (!man_y && auto_en && upd_y_s.flip) begin
                vy_neg_r <= ~vy_neg_r;
            end
        end
    end

    assign px = px_r;
    assign py = py_r;

    // Hit test. An object straddling the right/bottom edge simply has its
    // off-screen part never addressed; nothing is drawn wrapped around.
    logic [CALC_W-1:0] x_w_s;
    logic [CALC_W-1:0] y_w_s;
    logic [CALC_W-1:0] px_w_s;
    logic [CALC_W-1:0] py_w_s;
    logic [CALC_W-1:0] dx_s;
    logic [CALC_W-1:0] dy_s;
    logic              in_x_s;
    logic              in_y_s;
    logic              edge_x_s;
    logic              edge_y_s;

    assign x_w_s    = {1'b0, x};
    assign y_w_s    = {1'b0, y};
    assign px_w_s   = {1'b0, px_r};
    assign py_w_s   = {1'b0, py_r};
    assign dx_s     = x_w_s - px_w_s;
    assign dy_s     = y_w_s - py_w_s;
    assign in_x_s   = (x_w_s >= px_w_s) && (dx_s < CALC_W'(LARGHEZZA));
    assign in_y_s   = (y_w_s >= py_w_s) && (dy_s < CALC_W'(ALTEZZA));
    assign edge_x_s = (dx_s < CALC_W'(SPESSORE)) || (dx_s >= CALC_W'(LARGHEZZA - SPESSORE));
    assign edge_y_s = (dy_s < CALC_W'(SPESSORE)) || (dy_s >= CALC_W'(ALTEZZA - SPESSORE));

    assign frame_hit = in_x_s && in_y_s && (edge_x_s || edge_y_s);
    assign inner_hit = in_x_s && in_y_s && !edge_x_s && !edge_y_s;

endmodule

// File: rtl/movimenti_multi.sv
// -----------------------------------------------------------------------------
// movimenti_multi
// N framed rectangles moving once per frame, composited per pixel with fixed
// priority (lowest index on top) into registered RGB.
// Ports:
//   VGA_CLK            pixel clock
//   reset              synchronous active-low reset
//   VGA_VS             vertical sync; its rising edge yields the frame tick
//   disp_en, x, y      active-video flag and current pixel
//   sel                object for manual control and position readback
//   btn_x, btn_y       active-low nudge requests for object sel
//   dir_x, dir_y       nudge direction, 1 = increasing
//   auto_en            autonomous motion of all objects
//   wrap_mode          0 = bounce/clamp, 1 = wrap
//   r, g, b            pixel colour, 2 cycles after x/y/disp_en
//   hit_id             top object under the pixel, NO_HIT if none
//   pos_x, pos_y       position of object sel, 0 if sel >= N
// -----------------------------------------------------------------------------
module movimenti_multi
    import movimenti_pkg::*;
#(
    parameter int H         = 1280,
    parameter int V         = 1024,
    parameter int N         = 4,
    parameter int ALTEZZA   = 120,
    parameter int LARGHEZZA = 160,
    parameter int SPESSORE  = 10,
    parameter int STEP      = 2
) (
    input  logic               VGA_CLK,
    input  logic               reset,
    input  logic               VGA_VS,
    input  logic               disp_en,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [2:0]         sel,
    input  logic               btn_x,
    input  logic               btn_y,
    input  logic               dir_x,
    input  logic               dir_y,
    input  logic               auto_en,
    input  logic               wrap_mode,
    output logic [7:0]         r,
    output logic [7:0]         g,
    output logic [7:0]         b,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic [3:0]         hit_id
);

    // ---------------------------------------------------------------- frame tick
    logic vs_meta_r;
    logic vs_sync_r;
    logic vs_prev_r;
    logic frame_tick_r;

    // VS synchroniser and rising-edge pulse; one tick per VS pulse.
    always_ff @(posedge VGA_CLK) begin
        if (!reset) begin
            vs_meta_r    <= 1'b0;
            vs_sync_r    <= 1'b0;
            vs_prev_r    <= 1'b0;
            frame_tick_r <= 1'b0;
        end else begin
            vs_meta_r    <= VGA_VS;
            vs_sync_r    <= vs_meta_r;
            vs_prev_r    <= vs_sync_r;
            frame_tick_r <= vs_sync_r & ~vs_prev_r;
        end
    end

    // ---------------------------------------------------------------- objects
    logic               sel_valid_s;
    logic [N-1:0]       man_x_s;
    logic [N-1:0]       man_y_s;
    logic [N-1:0]       frame_s;
    logic [N-1:0]       inner_s;
    logic [COORD_W-1:0] px_s [N];
    logic [COORD_W-1:0] py_s [N];

    assign sel_valid_s = ({1'b0, sel} < 4'(N));

    for (genvar i = 0; i < N; i++) begin : g_obj
        assign man_x_s[i] = sel_valid_s && (sel == 3'(i)) && !btn_x;
        assign man_y_s[i] = sel_valid_s && (sel == 3'(i)) && !btn_y;

        sprite_obj #(
            .H         (H),
            .V         (V),
            .N         (N),
            .ALTEZZA   (ALTEZZA),
            .LARGHEZZA (LARGHEZZA),
            .SPESSORE  (SPESSORE),
            .STEP      (STEP),
            .IDX       (i)
        ) u_obj (
            .clk       (VGA_CLK),
            .reset     (reset),
            .frame_tick(frame_tick_r),
            .auto_en   (auto_en),
            .wrap_mode (wrap_mode),
            .man_x     (man_x_s[i]),
            .man_y     (man_y_s[i]),
            .dir_x     (dir_x),
            .dir_y     (dir_y),
            .x         (x),
            .y         (y),
            .px        (px_s[i]),
            .py        (py_s[i]),
            .frame_hit (frame_s[i]),
            .inner_hit (inner_s[i])
        );
    end

    // ---------------------------------------------------------------- pixel pipe
    logic [N-1:0] frame_r;
    logic [N-1:0] inner_r;
    logic         de_r;

    // Stage 1: per-object hit flags and aligned display enable.
    always_ff @(posedge VGA_CLK) begin
        if (!reset) begin
            frame_r <= {N{1'b0}};
            inner_r <= {N{1'b0}};
            de_r    <= 1'b0;
        end else begin
            frame_r <= frame_s;
            inner_r <= inner_s;
            de_r    <= disp_en;
        end
    end

    logic [23:0] pix_rgb_s;
    logic [3:0]  pix_hit_s;

    // Priority encoder: scan from the highest index down so the lowest hit wins.
    always_comb begin
        pix_rgb_s = BG_COLOUR;
        pix_hit_s = NO_HIT;
        for (int i = N - 1; i >= 0; i--) begin
            if (frame_r[i]) begin
                pix_rgb_s = PALETTE[i];
                pix_hit_s = 4'(i);
            end else if (inner_r[i]) begin
                pix_rgb_s = half_colour(PALETTE[i]);
                pix_hit_s = 4'(i);
            end else begin
                // object i not under the pixel; keep the result so far
            end
        end
    end

    // Stage 2: registered colour and hit index, blanked outside active video.
    always_ff @(posedge VGA_CLK) begin
        if (!reset) begin
            r      <= 8'h00;
            g      <= 8'h00;
            b      <= 8'h00;
            hit_id <= NO_HIT;
        end else if (!de_r) begin
            r      <= 8'h00;
            g      <= 8'h00;
            b      <= 8'h00;
            hit_id <= NO_HIT;
        end else begin
            r      <= pix_rgb_s[23:16];
            g      <= pix_rgb_s[15:8];
            b      <= pix_rgb_s[7:0];
            hit_id <= pix_hit_s;
        end
    end

    // ---------------------------------------------------------------- readback
    logic [COORD_W-1:0] sel_px_s;
    logic [COORD_W-1:0] sel_py_s;

    // Position mux; an out-of-range sel matches no object and reads 0.
    always_comb begin
        sel_px_s = {COORD_W{1'b0}};
        sel_py_s = {COORD_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (sel == 3'(i)) begin
                sel_px_s = px_s[i];
                sel_py_s = py_s[i];
            end else begin
                // not the selected object
            end
        end
    end

    // Registered position readback for the BCD display path.
    always_ff @(posedge VGA_CLK) begin
        if (!reset) begin
            pos_x <= {COORD_W{1'b0}};
            pos_y <= {COORD_W{1'b0}};
        end else begin
            pos_x <= sel_px_s;
            pos_y <= sel_py_s;
        end
    end

endmodule
